// File: rtl/alu_dec_pkg.sv
// Shared types and constants for the ALU/counter/decoder cluster.
package alu_dec_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_NOT = 3'd2,
      ALU_AND = 3'd3,
      ALU_OR  = 3'd4,
      ALU_XOR = 3'd5,
      ALU_SLT = 3'd6,
      ALU_EQ  = 3'd7
   } alu_op_e;

   localparam int DEC_SEL_W = 3;
   localparam int DEC_OUT_W = 8;

   function automatic logic [DEC_OUT_W-1:0] onehot_dec(input logic en,
                                                       input logic [DEC_SEL_W-1:0] sel);
      logic [DEC_OUT_W-1:0] y;
      y = '0;
      if (en) y = DEC_OUT_W'(1) << sel;
      return y;
   endfunction

endpackage

// File: rtl/alu_dec_cluster_if.sv
// Bundled ALU, counter and decoder signals of the cluster.
// cnt_tick is a single-cycle strobe: each clk edge on which it is high counts as one tick.
interface alu_dec_cluster_if #(
   parameter int ALU_W = 4,
   parameter int CNT_W = 3
);
   import alu_dec_pkg::*;

   logic [2:0]           alu_fnselec;
   logic [ALU_W-1:0]     alu_a;
   logic [ALU_W-1:0]     alu_b;
   logic [ALU_W-1:0]     alu_res;
   logic                 alu_zero;
   logic                 alu_overflow;
   logic                 alu_carry;
   logic                 cnt_en;
   logic                 cnt_tick;
   logic [CNT_W-1:0]     dec_counter_out;
   logic                 dec_en;
   logic [DEC_SEL_W-1:0] dec_x;
   logic [DEC_OUT_W-1:0] dec_y;

   modport master (
      output alu_fnselec, alu_a, alu_b, cnt_en, cnt_tick, dec_en, dec_x,
      input  alu_res, alu_zero, alu_overflow, alu_carry, dec_counter_out, dec_y
   );

   modport slave (
      input  alu_fnselec, alu_a, alu_b, cnt_en, cnt_tick, dec_en, dec_x,
      output alu_res, alu_zero, alu_overflow, alu_carry, dec_counter_out, dec_y
   );

endinterface

// File: rtl/alu_dec_cluster_alu_core.sv
// Combinational two's-complement ALU with zero, overflow and carry flags.
module alu_core
   import alu_dec_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [2:0]   fnselec,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] res,
   output logic         zero,
   output logic         overflow,
   output logic         carry
);

   alu_op_e      op;
   logic [W:0]   sum_add;
   logic [W:0]   sum_sub;
   logic         ovf_add;
   logic         ovf_sub;
   logic         slt_bit;

   assign op = alu_op_e'(fnselec);

   // Subtraction reuses the adder form a + ~b + 1 so carry=1 means no borrow.
   assign sum_add = {1'b0, a} + {1'b0, b};
   assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

   assign ovf_add = (a[W-1] == b[W-1]) && (sum_add[W-1] != a[W-1]);
   assign ovf_sub = (a[W-1] != b[W-1]) && (sum_sub[W-1] != a[W-1]);
   assign slt_bit = sum_sub[W-1] ^ ovf_sub;

   always_comb begin
      res      = '0;
      overflow = 1'b0;
      carry    = 1'b0;
      case (op)
         ALU_ADD: begin
            res      = sum_add[W-1:0];
            carry    = sum_add[W];
            overflow = ovf_add;
         end
         ALU_SUB: begin
            res      = sum_sub[W-1:0];
            carry    = sum_sub[W];
            overflow = ovf_sub;
         end
         ALU_NOT: res = ~a;
         ALU_AND: res = a & b;
         ALU_OR:  res = a | b;
         ALU_XOR: res = a ^ b;
         ALU_SLT: res = {{(W-1){1'b0}}, slt_bit};
         ALU_EQ:  res = {{(W-1){1'b0}}, (a == b)};
         default: begin
            res      = '0;
            overflow = 1'b0;
            carry    = 1'b0;
         end
      endcase
   end

   assign zero = (res == '0);

endmodule

// File: rtl/alu_dec_cluster.sv
// Board-demo arithmetic/decode cluster: ALU, tick-driven down-counter, 3-to-8 decoder.
// Define ALU_OUT_REG_EN to register the ALU result and flags (1-cycle latency).
module alu_dec_cluster
   import alu_dec_pkg::*;
#(
   parameter int ALU_W    = 4,
   parameter int CNT_W    = 3,
   parameter int CNT_INIT = 7
) (
   input  logic              clk,
   input  logic              resetn,
   alu_dec_cluster_if.slave  bus
);

   logic [ALU_W-1:0] core_res;
   logic             core_zero;
   logic             core_overflow;
   logic             core_carry;
   logic [CNT_W-1:0] cnt_q;

   alu_core #(.W(ALU_W)) u_alu_core (
      .fnselec  (bus.alu_fnselec),
      .a        (bus.alu_a),
      .b        (bus.alu_b),
      .res      (core_res),
      .zero     (core_zero),
      .overflow (core_overflow),
      .carry    (core_carry)
   );

`ifdef ALU_OUT_REG_EN
   logic [ALU_W-1:0] res_q;
   logic             zero_q;
   logic             overflow_q;
   logic             carry_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         res_q      <= '0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
         carry_q    <= 1'b0;
      end else begin
         res_q      <= core_res;
         zero_q     <= core_zero;
         overflow_q <= core_overflow;
         carry_q    <= core_carry;
      end
   end

   assign bus.alu_res      = res_q;
   assign bus.alu_zero     = zero_q;
   assign bus.alu_overflow = overflow_q;
   assign bus.alu_carry    = carry_q;
`else
   assign bus.alu_res      = core_res;
   assign bus.alu_zero     = core_zero;
   assign bus.alu_overflow = core_overflow;
   assign bus.alu_carry    = core_carry;
`endif

   // Reset beats a coincident tick; decrement wraps 0 -> all ones naturally.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= CNT_W'(CNT_INIT);
      end else if (bus.cnt_en && bus.cnt_tick) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign bus.dec_counter_out = cnt_q;
   assign bus.dec_y           = onehot_dec(bus.dec_en, bus.dec_x);

endmodule

// File: tb/tb_alu_dec_cluster.sv
// Directed self-checking bench for alu_dec_cluster (works with or without ALU_OUT_REG_EN).
module tb_alu_dec_cluster;
   import alu_dec_pkg::*;

   logic clk;
   logic resetn;
   int   checks   = 0;
   int   failures = 0;

   alu_dec_cluster_if #(.ALU_W(4), .CNT_W(3)) bus ();

   alu_dec_cluster #(.ALU_W(4), .CNT_W(3), .CNT_INIT(7)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive at a falling edge and sample one full cycle later, which covers both ALU builds.
   task automatic alu_step(input logic [2:0] fn, input logic [3:0] a, input logic [3:0] b);
      bus.alu_fnselec = fn;
      bus.alu_a       = a;
      bus.alu_b       = b;
      @(negedge clk);
   endtask

   task automatic check_alu(input string tag, input logic [3:0] res, input logic z,
                            input logic o, input logic c);
      check({tag, "_res"}, 32'(bus.alu_res), 32'(res));
      check({tag, "_zero"}, 32'(bus.alu_zero), 32'(z));
      check({tag, "_ovf"}, 32'(bus.alu_overflow), 32'(o));
      check({tag, "_carry"}, 32'(bus.alu_carry), 32'(c));
   endtask

   logic [2:0] exp_cnt [8] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
   logic [7:0] exp_dec [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

   initial begin
      resetn          = 1'b0;
      bus.alu_fnselec = 3'b000;
      bus.alu_a       = 4'b0111;
      bus.alu_b       = 4'b0001;
      bus.cnt_en      = 1'b0;
      bus.cnt_tick    = 1'b0;
      bus.dec_en      = 1'b0;
      bus.dec_x       = 3'd0;

      repeat (2) @(negedge clk);
      check("reset_cnt", 32'(bus.dec_counter_out), 32'd7);
`ifdef ALU_OUT_REG_EN
      check_alu("reset_alu", 4'b0000, 1'b0, 1'b0, 1'b0);
`endif
      resetn = 1'b1;

`ifdef ALU_OUT_REG_EN
      #1;
      check("reg_latency_res", 32'(bus.alu_res), 32'd0);
      @(negedge clk);
`else
      @(negedge clk);
`endif
      check_alu("add_7p1", 4'b1000, 1'b0, 1'b1, 1'b0);

      alu_step(3'b000, 4'b1111, 4'b0001);
      check_alu("add_fp1", 4'b0000, 1'b1, 1'b0, 1'b1);
      alu_step(3'b001, 4'b1000, 4'b0001);
      check_alu("sub_8m1", 4'b0111, 1'b0, 1'b1, 1'b1);
      alu_step(3'b001, 4'b0011, 4'b0101);
      check_alu("sub_3m5", 4'b1110, 1'b0, 1'b0, 1'b0);
      alu_step(3'b110, 4'b1110, 4'b0001);
      check_alu("slt_m2_1", 4'b0001, 1'b0, 1'b0, 1'b0);
      alu_step(3'b110, 4'b0001, 4'b1110);
      check_alu("slt_1_m2", 4'b0000, 1'b1, 1'b0, 1'b0);
      alu_step(3'b110, 4'b0111, 4'b1000);
      check_alu("slt_7_m8", 4'b0000, 1'b1, 1'b0, 1'b0);
      alu_step(3'b111, 4'b0101, 4'b0101);
      check_alu("eq_5_5", 4'b0001, 1'b0, 1'b0, 1'b0);
      alu_step(3'b111, 4'b0101, 4'b0100);
      check_alu("eq_5_4", 4'b0000, 1'b1, 1'b0, 1'b0);
      alu_step(3'b010, 4'b0101, 4'b0000);
      check_alu("not_5", 4'b1010, 1'b0, 1'b0, 1'b0);
      alu_step(3'b011, 4'b1100, 4'b1010);
      check_alu("and_c_a", 4'b1000, 1'b0, 1'b0, 1'b0);
      alu_step(3'b100, 4'b1100, 4'b1010);
      check_alu("or_c_a", 4'b1110, 1'b0, 1'b0, 1'b0);
      alu_step(3'b101, 4'b0101, 4'b0101);
      check_alu("xor_5_5", 4'b0000, 1'b1, 1'b0, 1'b0);

      // Counter: eight enabled ticks walk through the wrap.
      bus.cnt_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.cnt_tick = 1'b1;
         @(negedge clk);
         bus.cnt_tick = 1'b0;
         check($sformatf("cnt_tick%0d", i), 32'(bus.dec_counter_out), 32'(exp_cnt[i]));
      end
      @(negedge clk);
      check("cnt_hold_no_tick", 32'(bus.dec_counter_out), 32'd7);

      bus.cnt_en   = 1'b0;
      bus.cnt_tick = 1'b1;
      @(negedge clk);
      bus.cnt_tick = 1'b0;
      check("cnt_tick_disabled", 32'(bus.dec_counter_out), 32'd7);

      bus.cnt_en = 1'b1;
      repeat (4) begin
         bus.cnt_tick = 1'b1;
         @(negedge clk);
      end
      bus.cnt_tick = 1'b0;
      check("cnt_at_3", 32'(bus.dec_counter_out), 32'd3);

      resetn       = 1'b0;
      bus.cnt_tick = 1'b1;
      @(negedge clk);
      check("reset_over_tick", 32'(bus.dec_counter_out), 32'd7);
      resetn       = 1'b1;
      bus.cnt_tick = 1'b0;
      bus.cnt_en   = 1'b0;

      // Decoder
      bus.dec_en = 1'b1;
      for (int x = 0; x < 8; x++) begin
         bus.dec_x = 3'(x);
         #1;
         check($sformatf("dec_x%0d", x), 32'(bus.dec_y), 32'(exp_dec[x]));
      end
      bus.dec_en = 1'b0;
      bus.dec_x  = 3'd5;
      #1;
      check("dec_disabled", 32'(bus.dec_y), 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
